chipper_inject_unit: RTL and testbench

Per-node injection/ejection stage of the bufferless deflection router, sitting between the four mesh input channels and the permutation/arbitration stage.
- Ejects at most one flit per cycle that has arrived at this node.
- Injects queued local flits into any free or freed channel slot.
- Computes a one-hot productive direction for every outgoing slot.
- Node coordinates, coordinate width, payload width and queue depth are parameters, not constants.

---
 rtl/chipper_inject_unit_pkg.sv | 56 +++++
 rtl/chipper_inject_unit_if.sv | 34 +++
 rtl/chipper_inj_fifo.sv | 58 +++++
 rtl/chipper_inject_unit.sv | 150 +++++++++++++++
 tb/tb_chipper_inject_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chipper_inject_unit_pkg.sv
// +------------------------------------------------------------------+
// | chipper_pkg                                                      |
// | Shared constants, flit field helpers and route compute.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package chipper_pkg;

  localparam int NPORTS = 4;

  localparam int PORT_E = 0;
  localparam int PORT_W = 1;
  localparam int PORT_N = 2;
  localparam int PORT_S = 3;

  typedef logic [4:0] dir_t;

  localparam dir_t DIR_E     = 5'b00001;
  localparam dir_t DIR_W     = 5'b00010;
  localparam dir_t DIR_N     = 5'b00100;
  localparam dir_t DIR_S     = 5'b01000;
  localparam dir_t DIR_LOCAL = 5'b10000;

  // Helpers take the flit zero-extended to 64 bits and the field widths as arguments.
  function automatic logic [15:0] flit_row(input logic [63:0] f, input int coord_w, input int payload_w);
    logic [63:0] t;
    t = (f >> (coord_w + payload_w)) & ((64'd1 << coord_w) - 64'd1);
    return t[15:0];
  endfunction

  function automatic logic [15:0] flit_col(input logic [63:0] f, input int coord_w, input int payload_w);
    logic [63:0] t;
    t = (f >> payload_w) & ((64'd1 << coord_w) - 64'd1);
    return t[15:0];
  endfunction

  function automatic logic [63:0] flit_payload(input logic [63:0] f, input int payload_w);
    return f & ((64'd1 << payload_w) - 64'd1);
  endfunction

  // Column is resolved first, then row; matching both means this node.
  function automatic dir_t route_dir(input logic [15:0] row, input logic [15:0] col,
                                     input logic [15:0] my_row, input logic [15:0] my_col);
    dir_t d;
    if (col > my_col)      d = DIR_E;
    else if (col < my_col) d = DIR_W;
    else if (row > my_row) d = DIR_N;
    else if (row < my_row) d = DIR_S;
    else                   d = DIR_LOCAL;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chipper_inject_unit_if.sv
// +------------------------------------------------------------------+
// | chipper_inject_unit_if                                           |
// | Channel, injection and ejection signals of the inject stage.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface chipper_inject_unit_if #(
  parameter int FLIT_W = 14
);
  logic [3:0]          in_valid;
  logic [4*FLIT_W-1:0] in_flit;
  logic                inj_valid;
  logic [FLIT_W-1:0]   inj_flit;
  logic                inj_ready;
  logic [3:0]          out_valid;
  logic [4*FLIT_W-1:0] out_flit;
  logic [4*5-1:0]      out_dir;
  logic                ej_valid;
  logic [FLIT_W-1:0]   ej_flit;
  logic                starve;

  modport slave (
    input  in_valid, in_flit, inj_valid, inj_flit,
    output inj_ready, out_valid, out_flit, out_dir, ej_valid, ej_flit, starve
  );

  modport master (
    output in_valid, in_flit, inj_valid, inj_flit,
    input  inj_ready, out_valid, out_flit, out_dir, ej_valid, ej_flit, starve
  );
endinterface

`default_nettype wire

// File: rtl/chipper_inj_fifo.sv
// +------------------------------------------------------------------+
// | chipper_inj_fifo                                                 |
// | Synchronous count-based FIFO holding locally injected flits.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module chipper_inj_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_head,
  output logic                  o_empty,
  output logic                  o_full
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr;
  logic [c_AW-1:0]  r_rd;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (c_AW+1)'(DEPTH));
  assign o_head    = r_mem[r_rd];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + c_AW'(1);
      if (w_do_pop)  r_rd <= r_rd + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/chipper_inject_unit.sv
// +------------------------------------------------------------------+
// | chipper_inject_unit                                              |
// | Deflection router ejection/injection stage with route compute.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module chipper_inject_unit #(
  parameter int COORD_W    = 3,
  parameter int PAYLOAD_W  = 8,
  parameter int MY_ROW     = 4,
  parameter int MY_COL     = 4,
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 16
) (
  input wire logic             clk,
  input wire logic             rst,
  chipper_inject_unit_if.slave bus
);
  import chipper_pkg::*;

  localparam int c_ADDR_W = 2 * COORD_W;
  localparam int c_FLIT_W = c_ADDR_W + PAYLOAD_W;
  localparam int c_IDX_W  = $clog2(NPORTS);
  localparam int c_CNT_W  = $clog2(STARVE_LIM + 1);
  localparam logic [c_ADDR_W-1:0] c_MY_ADDR = {COORD_W'(MY_ROW), COORD_W'(MY_COL)};

  logic [c_FLIT_W-1:0] w_slot [NPORTS];
  logic [c_FLIT_W-1:0] w_nf   [NPORTS];
  dir_t                w_dir  [NPORTS];
  logic [NPORTS-1:0]   w_local, w_free, w_nv;
  logic [c_IDX_W-1:0]  w_ej_idx, w_inj_idx, w_scan;
  logic                w_ch_ej, w_inj_hit, w_inj_slot, w_head_local, w_head_eject, w_pop;
  logic [c_FLIT_W-1:0] w_head;
  logic                w_empty, w_full;
  logic [c_CNT_W-1:0]  w_cnt_nxt;

  logic [NPORTS-1:0]          r_out_valid;
  logic [NPORTS*c_FLIT_W-1:0] r_out_flit;
  logic [NPORTS*5-1:0]        r_out_dir;
  logic                       r_ej_valid;
  logic [c_FLIT_W-1:0]        r_ej_flit;
  logic                       r_starve;
  logic [c_IDX_W-1:0]         r_rr;
  logic [c_CNT_W-1:0]         r_cnt;

  chipper_inj_fifo #(.WIDTH(c_FLIT_W), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.inj_valid),
    .i_data  (bus.inj_flit),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  generate
    for (genvar i = 0; i < NPORTS; i++) begin : g_slot
      assign w_slot[i]  = bus.in_flit[i*c_FLIT_W +: c_FLIT_W];
      assign w_local[i] = bus.in_valid[i] && (w_slot[i][c_FLIT_W-1 -: c_ADDR_W] == c_MY_ADDR);
    end
  endgenerate

  always_comb begin
    w_ch_ej   = 1'b0;
    w_ej_idx  = '0;
    for (int i = NPORTS-1; i >= 0; i--) begin
      if (w_local[i]) begin
        w_ch_ej  = 1'b1;
        w_ej_idx = c_IDX_W'(i);
      end
    end

    w_free = ~bus.in_valid;
    if (w_ch_ej) w_free[w_ej_idx] = 1'b1;

    // A self-addressed head never takes a channel; it uses the eject port when idle.
    w_head_local = !w_empty && (w_head[c_FLIT_W-1 -: c_ADDR_W] == c_MY_ADDR);
    w_head_eject = w_head_local && !w_ch_ej;

    w_inj_hit = 1'b0;
    w_inj_idx = '0;
    w_scan    = '0;
    for (int k = NPORTS-1; k >= 0; k--) begin
      w_scan = r_rr + c_IDX_W'(k);
      if (w_free[w_scan]) begin
        w_inj_hit = 1'b1;
        w_inj_idx = w_scan;
      end
    end
    w_inj_slot = !w_empty && !w_head_local && w_inj_hit;
    w_pop      = w_inj_slot || w_head_eject;

    w_nv = bus.in_valid;
    if (w_ch_ej) w_nv[w_ej_idx] = 1'b0;
    for (int i = 0; i < NPORTS; i++) w_nf[i] = w_slot[i];
    if (w_inj_slot) begin
      w_nv[w_inj_idx] = 1'b1;
      w_nf[w_inj_idx] = w_head;
    end

    for (int i = 0; i < NPORTS; i++) begin
      w_dir[i] = route_dir(flit_row(64'(w_nf[i]), COORD_W, PAYLOAD_W),
                           flit_col(64'(w_nf[i]), COORD_W, PAYLOAD_W),
                           16'(MY_ROW), 16'(MY_COL));
    end

    if (w_empty || w_pop)                       w_cnt_nxt = '0;
    else if (r_cnt != c_CNT_W'(STARVE_LIM))     w_cnt_nxt = r_cnt + c_CNT_W'(1);
    else                                        w_cnt_nxt = r_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
      r_out_flit  <= '0;
      r_out_dir   <= '0;
      r_ej_valid  <= 1'b0;
      r_ej_flit   <= '0;
      r_starve    <= 1'b0;
      r_rr        <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= w_nv;
      for (int i = 0; i < NPORTS; i++) begin
        r_out_flit[i*c_FLIT_W +: c_FLIT_W] <= w_nv[i] ? w_nf[i] : '0;
        r_out_dir[i*5 +: 5]                <= w_nv[i] ? w_dir[i] : '0;
      end
      r_ej_valid <= w_ch_ej || w_head_eject;
      if (w_ch_ej)           r_ej_flit <= w_slot[w_ej_idx];
      else if (w_head_eject) r_ej_flit <= w_head;
      else                   r_ej_flit <= '0;
      if (w_inj_slot) r_rr <= w_inj_idx + c_IDX_W'(1);
      r_cnt    <= w_cnt_nxt;
      r_starve <= (w_cnt_nxt == c_CNT_W'(STARVE_LIM));
    end
  end

  assign bus.inj_ready = !w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_flit  = r_out_flit;
  assign bus.out_dir   = r_out_dir;
  assign bus.ej_valid  = r_ej_valid;
  assign bus.ej_flit   = r_ej_flit;
  assign bus.starve    = r_starve;

endmodule

`default_nettype wire

// File: tb/tb_chipper_inject_unit.sv
// +------------------------------------------------------------------+
// | tb_chipper_inject_unit                                           |
// | Directed stimulus with a per-cycle reference model.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_chipper_inject_unit;
  localparam int FW   = 14;
  localparam int QD   = 4;
  localparam int SLIM = 16;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  chipper_inject_unit_if #(.FLIT_W(FW)) bus ();

  chipper_inject_unit #(
    .COORD_W(3), .PAYLOAD_W(8), .MY_ROW(4), .MY_COL(4), .QDEPTH(QD), .STARVE_LIM(SLIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input int r, input int c, input int p);
    return {3'(r), 3'(c), 8'(p)};
  endfunction

  function automatic logic [4:0] exp_route(input logic [FW-1:0] f);
    int r, c;
    r = int'(f[13:11]);
    c = int'(f[10:8]);
    if (c > 4) return 5'b00001;
    if (c < 4) return 5'b00010;
    if (r > 4) return 5'b00100;
    if (r < 4) return 5'b01000;
    return 5'b10000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: local queue, rotating start slot, blocked-cycle count.
  logic [FW-1:0] mq[$];
  int            m_rr   = 0;
  int            m_scnt = 0;
  logic [3:0]    e_ov   = '0;
  logic [FW-1:0] e_of[4];
  logic [4:0]    e_od[4];
  logic          e_ejv  = 1'b0;
  logic [FW-1:0] e_ejf  = '0;
  logic          e_st   = 1'b0;

  always @(posedge clk) begin
    int ej, sz0, idx;
    bit popped, placed;
    logic [FW-1:0] slot[4];
    logic [FW-1:0] hd;
    if (rst) begin
      mq.delete();
      m_rr = 0; m_scnt = 0;
      e_ov = '0; e_ejv = 1'b0; e_ejf = '0; e_st = 1'b0;
      for (int i = 0; i < 4; i++) begin e_of[i] = '0; e_od[i] = '0; end
    end else begin
      ej = -1;
      for (int i = 0; i < 4; i++) begin
        slot[i] = bus.in_flit[i*FW +: FW];
        e_ov[i] = bus.in_valid[i];
        if (ej < 0 && bus.in_valid[i] && slot[i][13:8] == 6'b100100) ej = i;
      end
      e_ejv = 1'b0; e_ejf = '0;
      if (ej >= 0) begin e_ejv = 1'b1; e_ejf = slot[ej]; e_ov[ej] = 1'b0; end
      sz0 = mq.size();
      popped = 0;
      if (sz0 > 0) begin
        hd = mq[0];
        if (hd[13:8] == 6'b100100) begin
          if (!e_ejv) begin e_ejv = 1'b1; e_ejf = hd; popped = 1; end
        end else begin
          placed = 0;
          for (int k = 0; k < 4; k++) begin
            idx = (m_rr + k) % 4;
            if (!placed && !e_ov[idx]) begin
              placed = 1; e_ov[idx] = 1'b1; slot[idx] = hd; m_rr = (idx + 1) % 4; popped = 1;
            end
          end
        end
        if (popped) void'(mq.pop_front());
      end
      if (sz0 > 0 && !popped) m_scnt = (m_scnt < SLIM) ? m_scnt + 1 : SLIM;
      else m_scnt = 0;
      e_st = (m_scnt == SLIM);
      if (bus.inj_valid && sz0 < QD) mq.push_back(bus.inj_flit);
      for (int i = 0; i < 4; i++) begin
        e_of[i] = e_ov[i] ? slot[i] : '0;
        e_od[i] = e_ov[i] ? exp_route(slot[i]) : '0;
      end
    end
    #1;
    check("m_out_valid", 64'(bus.out_valid), 64'(e_ov));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("m_out_flit%0d", i), 64'(bus.out_flit[i*FW +: FW]), 64'(e_of[i]));
      check($sformatf("m_out_dir%0d", i), 64'(bus.out_dir[i*5 +: 5]), 64'(e_od[i]));
    end
    check("m_ej_valid", 64'(bus.ej_valid), 64'(e_ejv));
    check("m_ej_flit", 64'(bus.ej_flit), 64'(e_ejf));
    check("m_starve", 64'(bus.starve), 64'(e_st));
    check("m_inj_ready", 64'(bus.inj_ready), 64'(mq.size() < QD));
  end

  task automatic idle();
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.inj_valid = 1'b0;
    bus.inj_flit  = '0;
  endtask

  task automatic set_slot(input int i, input logic [FW-1:0] f);
    bus.in_flit[i*FW +: FW] = f;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.in_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_slot(i, mk(4, 4, i));
    bus.inj_valid = 1'b1;
    bus.inj_flit  = mk(1, 1, 8'h77);
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_flit", 64'(bus.out_flit), 64'h0);
    check("rst_ej_valid", 64'(bus.ej_valid), 64'h0);
    check("rst_starve", 64'(bus.starve), 64'h0);
    rst = 1'b0;
    idle();
    check("rdy_after_rst", 64'(bus.inj_ready), 64'h1);

    // Pass-through routing
    bus.in_valid = 4'b1101;
    set_slot(0, mk(2, 6, 8'h11));
    set_slot(2, mk(6, 4, 8'h22));
    set_slot(3, mk(1, 4, 8'h33));
    @(negedge clk);
    check("rt_valid", 64'(bus.out_valid), 64'hD);
    check("rt_dir0", 64'(bus.out_dir[4:0]), 64'b00001);
    check("rt_dir2", 64'(bus.out_dir[14:10]), 64'b00100);
    check("rt_dir3", 64'(bus.out_dir[19:15]), 64'b01000);
    check("rt_flit0", 64'(bus.out_flit[13:0]), 64'(mk(2, 6, 8'h11)));

    // Eject slot1 while queued flit fills its place
    idle();
    bus.inj_valid = 1'b1;
    bus.inj_flit  = mk(0, 0, 8'h33);
    @(negedge clk);
    idle();
    bus.in_valid = 4'hF;
    set_slot(0, mk(2, 6, 8'h10));
    set_slot(1, mk(4, 4, 8'hA1));
    set_slot(2, mk(6, 4, 8'h12));
    set_slot(3, mk(4, 4, 8'hA3));
    @(negedge clk);
    check("ej_valid", 64'(bus.ej_valid), 64'h1);
    check("ej_flit", 64'(bus.ej_flit), 64'(mk(4, 4, 8'hA1)));
    check("ej_out_valid", 64'(bus.out_valid), 64'hF);
    check("ej_inj_flit1", 64'(bus.out_flit[27:14]), 64'(mk(0, 0, 8'h33)));
    check("ej_dir1", 64'(bus.out_dir[9:5]), 64'b00010);
    check("ej_dir3", 64'(bus.out_dir[19:15]), 64'b10000);

    // Round-robin slot selection from a fresh pointer
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.inj_valid = (k < 4);
      bus.inj_flit  = mk(7, 7, k);
      @(negedge clk);
      if (k > 0) begin
        check("rr_valid", 64'(bus.out_valid), 64'(4'b0001 << (k - 1)));
        check("rr_flit", 64'(bus.out_flit[(k-1)*FW +: FW]), 64'(mk(7, 7, k - 1)));
        check("rr_ready", 64'(bus.inj_ready), 64'h1);
      end
    end
    idle();
    @(negedge clk);

    // Full queue and starvation with every channel busy
    bus.in_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_slot(i, mk(0, 0, i));
    bus.inj_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.inj_flit = mk(7, 7, 8'h50 + k);
      @(negedge clk);
    end
    check("full_ready", 64'(bus.inj_ready), 64'h0);
    bus.inj_flit = mk(7, 7, 8'h5F);
    repeat (12) @(negedge clk);
    check("starve_pre", 64'(bus.starve), 64'h0);
    @(negedge clk);
    check("starve_set", 64'(bus.starve), 64'h1);
    bus.inj_valid = 1'b0;
    bus.in_valid  = 4'b1011;
    @(negedge clk);
    check("free_valid", 64'(bus.out_valid), 64'hF);
    check("free_flit2", 64'(bus.out_flit[41:28]), 64'(mk(7, 7, 8'h50)));
    check("free_dir2", 64'(bus.out_dir[14:10]), 64'b00001);
    check("free_starve", 64'(bus.starve), 64'h0);
    check("free_ready", 64'(bus.inj_ready), 64'h1);
    idle();
    repeat (4) @(negedge clk);

    // Self-addressed queue head
    bus.inj_valid = 1'b1;
    bus.inj_flit  = mk(4, 4, 8'hC1);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("self_ej_valid", 64'(bus.ej_valid), 64'h1);
    check("self_ej_flit", 64'(bus.ej_flit), 64'(mk(4, 4, 8'hC1)));
    check("self_out_valid", 64'(bus.out_valid), 64'h0);
    bus.inj_valid = 1'b1;
    bus.inj_flit  = mk(4, 4, 8'hC2);
    @(negedge clk);
    idle();
    bus.in_valid = 4'b0001;
    set_slot(0, mk(4, 4, 8'hD0));
    @(negedge clk);
    check("self_wait_ej", 64'(bus.ej_flit), 64'(mk(4, 4, 8'hD0)));
    check("self_wait_ov", 64'(bus.out_valid), 64'h0);
    idle();
    @(negedge clk);
    check("self_late_v", 64'(bus.ej_valid), 64'h1);
    check("self_late_f", 64'(bus.ej_flit), 64'(mk(4, 4, 8'hC2)));
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
